// File: rtl/seq_delay_monitor.sv
// seq_delay_monitor
//   Watches NUM_CH independent channels for the sequence
//   "a, then b between MIN_DELAY and MAX_DELAY cycles later".
//   Each start event opens an attempt that ages by one bit position per
//   cycle. A b event resolves every eligible attempt as matched. An attempt
//   that reaches MAX_DELAY without b resolves as failed.
//
// Ports
//   clk        : single clock, all state changes on its rising edge
//   rst        : asynchronous active-high reset
//   en         : allows a to open new attempts (pending ones keep aging)
//   clr        : synchronous clear of attempts, pulses and counters
//   a, b       : per-channel start / completion events
//   match      : registered one-cycle pulse, >=1 attempt matched
//   fail       : registered one-cycle pulse, >=1 attempt expired
//   match_cnt  : saturating match counters, channel i at [i*CNT_W +: CNT_W]
//   fail_cnt   : saturating fail counters, same packing
module seq_delay_monitor #(
  parameter int NUM_CH    = 2,
  parameter int MIN_DELAY = 1,
  parameter int MAX_DELAY = 3,
  parameter int CNT_W     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    clr,
  input  logic [NUM_CH-1:0]       a,
  input  logic [NUM_CH-1:0]       b,
  output logic [NUM_CH-1:0]       match,
  output logic [NUM_CH-1:0]       fail,
  output logic [NUM_CH*CNT_W-1:0] match_cnt,
  output logic [NUM_CH*CNT_W-1:0] fail_cnt
);

  // Bit k of a pending vector is an attempt of age k+1. An attempt may be
  // completed by b once its age is at least MIN_DELAY.
  function automatic logic [MAX_DELAY-1:0] eligible_mask();
    logic [MAX_DELAY-1:0] m;
    m = '0;
    for (int k = 0; k < MAX_DELAY; k++) begin
      m[k] = ((k + 1) >= MIN_DELAY);
    end
    return m;
  endfunction

  localparam logic [MAX_DELAY-1:0] ELIG = eligible_mask();
  localparam logic [CNT_W-1:0]     CNT_MAX = {CNT_W{1'b1}};

  logic [MAX_DELAY-1:0] pending     [NUM_CH];
  logic [MAX_DELAY-1:0] pending_nxt [NUM_CH];
  logic [MAX_DELAY-1:0] survive     [NUM_CH];
  logic [NUM_CH-1:0]    hit;
  logic [NUM_CH-1:0]    expire;

  // Resolve the current attempts and age the survivors. The oldest bit
  // always leaves the vector: it is either matched by b or expires. The
  // new attempt enters at age 1 after the shift, so a b in the same cycle
  // can never match it.
  always_comb begin
    hit    = '0;
    expire = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      hit[i]         = b[i] & (|(pending[i] & ELIG));
      expire[i]      = pending[i][MAX_DELAY-1] & ~b[i];
      survive[i]     = pending[i] & ~(b[i] ? ELIG : '0);
      pending_nxt[i] = (survive[i] << 1) | MAX_DELAY'(en & a[i]);
    end
  end

  // State, pulses and saturating counters for all channels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        pending[i] <= '0;
      end
      match     <= '0;
      fail      <= '0;
      match_cnt <= '0;
      fail_cnt  <= '0;
    end else if (clr) begin
      for (int i = 0; i < NUM_CH; i++) begin
        pending[i] <= '0;
      end
      match     <= '0;
      fail      <= '0;
      match_cnt <= '0;
      fail_cnt  <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        pending[i] <= pending_nxt[i];
        if (hit[i] && (match_cnt[i*CNT_W +: CNT_W] != CNT_MAX)) begin
          match_cnt[i*CNT_W +: CNT_W] <= match_cnt[i*CNT_W +: CNT_W] + CNT_W'(1);
        end
        if (expire[i] && (fail_cnt[i*CNT_W +: CNT_W] != CNT_MAX)) begin
          fail_cnt[i*CNT_W +: CNT_W] <= fail_cnt[i*CNT_W +: CNT_W] + CNT_W'(1);
        end
      end
      match <= hit;
      fail  <= expire;
    end
  end

endmodule

// File: tb/tb_seq_delay_monitor.sv
// tb_seq_delay_monitor
//   Self-checking bench for seq_delay_monitor with NUM_CH=2, MIN_DELAY=1,
//   MAX_DELAY=3, CNT_W=4. Expected outputs for each cycle are pushed to a
//   scoreboard queue when the stimulus is driven and popped when the DUT
//   outputs for that cycle are sampled. Directed cases come from a vector
//   table; saturation, reset and random traffic use a small attempt model.
module tb_seq_delay_monitor;

  localparam int NCH   = 2;
  localparam int MIN_D = 1;
  localparam int MAX_D = 3;
  localparam int CW    = 4;
  localparam int SAT   = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic            clr;
  logic [NCH-1:0]  a;
  logic [NCH-1:0]  b;
  logic [NCH-1:0]  match;
  logic [NCH-1:0]  fail;
  logic [NCH*CW-1:0] match_cnt;
  logic [NCH*CW-1:0] fail_cnt;

  typedef struct {
    logic [NCH-1:0]    m;
    logic [NCH-1:0]    f;
    logic [NCH*CW-1:0] mc;
    logic [NCH*CW-1:0] fc;
  } exp_t;

  typedef struct {
    logic [NCH-1:0] a;
    logic [NCH-1:0] b;
    logic           en;
    logic           clr;
    logic [NCH-1:0] m;
    logic [NCH-1:0] f;
  } vec_t;

  exp_t sb_q[$];
  vec_t tbl[$];

  int compared   = 0;
  int mismatched = 0;

  // Model state: number of open attempts per channel and age.
  int pend [NCH][MAX_D+2];
  int mcnt [NCH];
  int fcnt [NCH];

  seq_delay_monitor #(
    .NUM_CH(NCH), .MIN_DELAY(MIN_D), .MAX_DELAY(MAX_D), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .a(a), .b(b),
    .match(match), .fail(fail), .match_cnt(match_cnt), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "[TB] timeout");
  end

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_output(input string tag, input exp_t e);
    check({tag, ".match"},     int'(match),     int'(e.m));
    check({tag, ".fail"},      int'(fail),      int'(e.f));
    check({tag, ".match_cnt"}, int'(match_cnt), int'(e.mc));
    check({tag, ".fail_cnt"},  int'(fail_cnt),  int'(e.fc));
  endtask

  task automatic apply_stimulus(input string tag, input logic [NCH-1:0] ia,
                                input logic [NCH-1:0] ib, input logic ien,
                                input logic iclr, input exp_t e);
    exp_t got;
    @(negedge clk);
    a = ia; b = ib; en = ien; clr = iclr;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check({tag, ".scoreboard_empty"}, 1, 0);
    end else begin
      got = sb_q.pop_front();
      check_output(tag, got);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      for (int k = 0; k < MAX_D + 2; k++) pend[c][k] = 0;
      mcnt[c] = 0;
      fcnt[c] = 0;
    end
  endtask

  // Age every open attempt by one cycle and resolve it against b.
  task automatic model_step(input logic [NCH-1:0] ia, input logic [NCH-1:0] ib,
                            input logic ien, input logic iclr, output exp_t e);
    int np [MAX_D+2];
    logic m, f;
    e.m = '0; e.f = '0; e.mc = '0; e.fc = '0;
    for (int c = 0; c < NCH; c++) begin
      m = 1'b0; f = 1'b0;
      for (int k = 0; k < MAX_D + 2; k++) np[k] = 0;
      if (iclr) begin
        mcnt[c] = 0;
        fcnt[c] = 0;
      end else begin
        for (int k = 1; k <= MAX_D; k++) begin
          if (pend[c][k] > 0) begin
            if (ib[c] && k >= MIN_D) m = 1'b1;
            else if (k == MAX_D)     f = 1'b1;
            else                     np[k+1] += pend[c][k];
          end
        end
        if (ien && ia[c]) np[1] += 1;
        if (m && mcnt[c] < SAT) mcnt[c]++;
        if (f && fcnt[c] < SAT) fcnt[c]++;
      end
      for (int k = 0; k < MAX_D + 2; k++) pend[c][k] = np[k];
      e.m[c] = m;
      e.f[c] = f;
      e.mc[c*CW +: CW] = mcnt[c][CW-1:0];
      e.fc[c*CW +: CW] = fcnt[c][CW-1:0];
    end
  endtask

  task automatic run_model(input string tag, input logic [NCH-1:0] ia,
                           input logic [NCH-1:0] ib, input logic ien,
                           input logic iclr);
    exp_t e;
    model_step(ia, ib, ien, iclr, e);
    apply_stimulus(tag, ia, ib, ien, iclr, e);
  endtask

  task automatic add_vec(input logic [NCH-1:0] va, input logic [NCH-1:0] vb,
                         input logic ven, input logic vclr,
                         input logic [NCH-1:0] vm, input logic [NCH-1:0] vf);
    vec_t v;
    v.a = va; v.b = vb; v.en = ven; v.clr = vclr; v.m = vm; v.f = vf;
    tbl.push_back(v);
  endtask

  initial begin
    exp_t e;
    int tm [NCH];
    int tf [NCH];

    rst = 1'b1; en = 1'b0; clr = 1'b0; a = '0; b = '0;
    model_reset();

    // Reset state, before any clock edge matters.
    #12;
    check("reset.match",     int'(match),     0);
    check("reset.fail",      int'(fail),      0);
    check("reset.match_cnt", int'(match_cnt), 0);
    check("reset.fail_cnt",  int'(fail_cnt),  0);
    rst = 1'b0;

    // Directed vectors: inputs for one cycle and the pulses seen next cycle.
    add_vec(2'b01, 2'b00, 1, 0, 2'b00, 2'b00); // 0  ch0 start
    add_vec(2'b00, 2'b00, 1, 0, 2'b00, 2'b00); // 1
    add_vec(2'b00, 2'b01, 1, 0, 2'b01, 2'b00); // 2  b at age 2
    add_vec(2'b10, 2'b00, 1, 0, 2'b00, 2'b00); // 3  ch1 start
    add_vec(2'b10, 2'b00, 1, 0, 2'b00, 2'b00); // 4  ch1 overlap
    add_vec(2'b00, 2'b10, 1, 0, 2'b10, 2'b00); // 5  both matched, one pulse
    add_vec(2'b00, 2'b00, 1, 0, 2'b00, 2'b00); // 6
    add_vec(2'b00, 2'b00, 1, 0, 2'b00, 2'b00); // 7
    add_vec(2'b01, 2'b00, 1, 0, 2'b00, 2'b00); // 8  ch0 start, no b
    add_vec(2'b00, 2'b00, 1, 0, 2'b00, 2'b00); // 9
    add_vec(2'b00, 2'b00, 1, 0, 2'b00, 2'b00); // 10
    add_vec(2'b00, 2'b00, 1, 0, 2'b00, 2'b01); // 11 expires
    add_vec(2'b00, 2'b00, 1, 0, 2'b00, 2'b00); // 12
    add_vec(2'b01, 2'b01, 1, 0, 2'b00, 2'b00); // 13 a and b together
    add_vec(2'b00, 2'b00, 1, 0, 2'b00, 2'b00); // 14
    add_vec(2'b00, 2'b00, 1, 0, 2'b00, 2'b00); // 15
    add_vec(2'b00, 2'b00, 1, 0, 2'b00, 2'b01); // 16 expires
    add_vec(2'b01, 2'b00, 0, 0, 2'b00, 2'b00); // 17 en low, no attempt
    add_vec(2'b00, 2'b01, 1, 0, 2'b00, 2'b00); // 18 nothing to match
    add_vec(2'b01, 2'b00, 1, 0, 2'b00, 2'b00); // 19
    add_vec(2'b00, 2'b00, 1, 0, 2'b00, 2'b00); // 20
    add_vec(2'b00, 2'b00, 1, 0, 2'b00, 2'b00); // 21
    add_vec(2'b00, 2'b01, 1, 0, 2'b01, 2'b00); // 22 b at age MAX matches
    add_vec(2'b00, 2'b00, 1, 0, 2'b00, 2'b00); // 23
    add_vec(2'b11, 2'b00, 1, 0, 2'b00, 2'b00); // 24 both channels start
    add_vec(2'b00, 2'b00, 1, 0, 2'b00, 2'b00); // 25
    add_vec(2'b00, 2'b01, 1, 0, 2'b01, 2'b00); // 26 only ch0 matched
    add_vec(2'b00, 2'b00, 1, 0, 2'b00, 2'b10); // 27 ch1 expires
    add_vec(2'b00, 2'b00, 1, 0, 2'b00, 2'b00); // 28
    add_vec(2'b01, 2'b00, 1, 0, 2'b00, 2'b00); // 29 attempt then clear
    add_vec(2'b01, 2'b00, 1, 1, 2'b00, 2'b00); // 30 clr wins over a
    add_vec(2'b00, 2'b01, 1, 0, 2'b00, 2'b00); // 31 nothing left to match
    add_vec(2'b00, 2'b00, 1, 0, 2'b00, 2'b00); // 32
    add_vec(2'b00, 2'b00, 1, 0, 2'b00, 2'b00); // 33
    add_vec(2'b00, 2'b00, 1, 0, 2'b00, 2'b00); // 34

    for (int c = 0; c < NCH; c++) begin
      tm[c] = 0;
      tf[c] = 0;
    end
    for (int r = 0; r < tbl.size(); r++) begin
      e.m = tbl[r].m;
      e.f = tbl[r].f;
      for (int c = 0; c < NCH; c++) begin
        if (tbl[r].clr) begin
          tm[c] = 0;
          tf[c] = 0;
        end else begin
          if (tbl[r].m[c] && tm[c] < SAT) tm[c]++;
          if (tbl[r].f[c] && tf[c] < SAT) tf[c]++;
        end
        e.mc[c*CW +: CW] = tm[c][CW-1:0];
        e.fc[c*CW +: CW] = tf[c][CW-1:0];
      end
      apply_stimulus($sformatf("vec%0d", r), tbl[r].a, tbl[r].b, tbl[r].en,
                     tbl[r].clr, e);
    end

    // Counter saturation with back-to-back a/b pairs, then a clear.
    model_reset();
    for (int i = 0; i < 20; i++) run_model($sformatf("sat%0d", i), 2'b01, 2'b01, 1, 0);
    check("sat.match_cnt0", int'(match_cnt[CW-1:0]), SAT);
    run_model("sat_hold", 2'b00, 2'b00, 1, 0);
    check("sat_hold.match_cnt0", int'(match_cnt[CW-1:0]), SAT);
    run_model("sat_clr", 2'b00, 2'b00, 1, 1);
    check("sat_clr.match_cnt", int'(match_cnt), 0);

    // Random traffic on both channels.
    for (int i = 0; i < 200; i++) begin
      run_model($sformatf("rnd%0d", i), 2'($urandom_range(0, 3)),
                2'($urandom_range(0, 3)), ($urandom_range(0, 7) != 0),
                ($urandom_range(0, 39) == 0));
    end

    // Reset in the middle of an attempt discards it silently.
    run_model("pre_rst0", 2'b11, 2'b00, 1, 0);
    run_model("pre_rst1", 2'b00, 2'b11, 1, 0);
    run_model("rst_a", 2'b01, 2'b00, 1, 0);
    #2;
    a = '0; b = '0;
    rst = 1'b1;
    #1;
    check("rst_async.match_cnt", int'(match_cnt), 0);
    check("rst_async.fail_cnt",  int'(fail_cnt),  0);
    check("rst_async.match",     int'(match),     0);
    check("rst_async.fail",      int'(fail),      0);
    @(posedge clk);
    #1;
    check("rst_held.match", int'(match), 0);
    check("rst_held.fail",  int'(fail),  0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    run_model("post_rst2", 2'b00, 2'b00, 1, 0);
    run_model("post_rst3", 2'b00, 2'b01, 1, 0);
    for (int i = 0; i < 4; i++) run_model($sformatf("post_rst_idle%0d", i), 2'b00, 2'b00, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/seq_delay_monitor.md
SEQ_DELAY_MONITOR -- requirements
Module: seq_delay_monitor

Interface
REQ-001 Parameter NUM_CH, default 2: number of independent a/b channels, range 1..8.
REQ-002 Parameter MIN_DELAY, default 1: earliest cycle after a at which b completes the sequence, range 1..MAX_DELAY.
REQ-003 Parameter MAX_DELAY, default 3: latest cycle after a at which b completes the sequence, range MIN_DELAY..16.
REQ-004 Parameter CNT_W, default 4: width of each per-channel counter, range 2..16.
REQ-005 clk  input  1  single clock; all state updates on posedge clk.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 en  input  1  when high, a starts new attempts; when low, no new attempts start, and pending attempts keep aging.
REQ-008 clr  input  1  synchronous clear of all pending attempts, outputs and counters.
REQ-009 a  input  NUM_CH  per-channel sequence start event.
REQ-010 b  input  NUM_CH  per-channel sequence completion event.
REQ-011 match  output  NUM_CH  registered one-cycle pulse per channel: sequence a ##[MIN_DELAY:MAX_DELAY] b completed.
REQ-012 fail  output  NUM_CH  registered one-cycle pulse per channel: at least one attempt expired without b.
REQ-013 match_cnt  output  NUM_CH*CNT_W  per-channel saturating match counters; channel i occupies bits [i*CNT_W +: CNT_W].
REQ-014 fail_cnt  output  NUM_CH*CNT_W  per-channel saturating fail counters, same packing.

Function
REQ-015 Each channel SHALL hold a pending-age vector of MAX_DELAY bits; bit k-1 set = an unresolved attempt started k cycles ago.
REQ-016 At a posedge with en=1, clr=0 and a[i]=1, channel i SHALL record a new attempt of age 1 for the next cycle.
REQ-017 Overlapping attempts SHALL be tracked independently, one per start cycle, with no limit beyond the vector.
REQ-018 At a posedge with b[i]=1, every pending attempt of age k, MIN_DELAY<=k<=MAX_DELAY, SHALL resolve as matched and be cleared.
REQ-019 Pending attempts with age < MIN_DELAY SHALL be unaffected by b and keep aging.
REQ-020 At a posedge where an attempt has age MAX_DELAY and b[i]=0, that attempt SHALL resolve as failed and be cleared.
REQ-021 An attempt at age MAX_DELAY with b[i]=1 SHALL count as matched, never failed.
REQ-022 a[i] and b[i] high in the same cycle: b resolves existing eligible attempts and a starts a new attempt; the new attempt is never matched by that same b.
REQ-023 match[i] SHALL be high for exactly the cycle after any posedge at which >=1 attempt matched; several attempts matched at once give one pulse.
REQ-024 fail[i] SHALL be high for exactly the cycle after any posedge at which >=1 attempt failed.
REQ-025 match and fail for the same channel MAY both pulse in the same cycle.
REQ-026 match_cnt[i] SHALL increment by 1 per match pulse and saturate at 2^CNT_W-1.
REQ-027 fail_cnt[i] SHALL increment by 1 per fail pulse and saturate at 2^CNT_W-1.
REQ-028 clr=1 at a posedge SHALL clear all pending vectors, match, fail and both counters; a, b and en are ignored that cycle.
REQ-029 Channels SHALL be fully independent; activity on one channel never affects another.

Reset
REQ-030 While rst=1, all pending vectors, match, fail, match_cnt and fail_cnt SHALL be 0 immediately, independent of clk.
REQ-031 Attempts in flight when rst asserts SHALL be discarded with no match or fail pulse after rst deasserts.
REQ-032 The first attempt SHALL be recordable at the first posedge with rst low.

Verification (NUM_CH=2, MIN_DELAY=1, MAX_DELAY=3, CNT_W=4)
REQ-033 a[0]=1 at cycle 0, b[0]=1 at cycle 2 -> match[0]=1 at cycle 3 only, match_cnt[0]=1, fail[0] stays 0, channel 1 all zero.
REQ-034 a[0]=1 at cycle 0, b[0] held 0 -> fail[0]=1 at cycle 4 only, fail_cnt[0]=1, match[0]=0.
REQ-035 a[1]=1 at cycles 0 and 1, b[1]=1 at cycle 2 -> single match[1] pulse at cycle 3, match_cnt[1]=1, no fail at cycles 4-5.
REQ-036 a[0]=b[0]=1 at cycle 0 with nothing pending, b[0]=0 after -> no match; fail[0]=1 at cycle 4.
REQ-037 20 back-to-back a/b pairs on channel 0 -> match_cnt[0] saturates at 15 and holds; clr=1 one cycle -> all counters 0 next cycle.
REQ-038 a[0]=1 at cycle 0, rst pulsed at cycle 1, b[0]=1 at cycle 3 -> outputs 0 during rst, no match or fail pulse afterwards.
